branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Execute-stage companion to the decode-stage static predictor. Captures each decoded branch
//  with its prediction into a D->E register, then compares the prediction with the actual
//  condition computed in execute. On a mispredict it drives the fetch redirect PC and a
//  one-cycle F/D flush. Keeps saturating branch and mispredict counters for performance.
// PARAMETERS
//  DATA_WIDTH  32  PC / immediate width
//  CNT_WIDTH   32  width of the performance counters
// PORTS
//  clk               in   1           system clock, all state on rising edge
//  rst               in   1           synchronous, active-high reset
//  stall_e           in   1           hold E-stage register (hazard stall)
//  flush_e           in   1           load a bubble into the E-stage register
//  Branch_d          in   1           decode-stage instruction is a conditional branch
//  predict_taken_d   in   1           decode-stage prediction (1 = taken)
//  PC_d              in   DATA_WIDTH  PC of decode-stage instruction
//  ImmExt_d          in   DATA_WIDTH  sign-extended branch offset
//  branch_cond_e     in   1           actual branch outcome from execute (1 = taken), valid same cycle
//  redirect_valid    out  1           fetch must load redirect_pc this cycle
//  redirect_pc       out  DATA_WIDTH  corrected fetch address
//  flush_fd          out  1           squash F and D stage instructions (wrong path)
//  mispredict_e      out  1           E-stage branch resolved against its prediction
//  branch_count      out  CNT_WIDTH   resolved branches since reset
//  mispredict_count  out  CNT_WIDTH   mispredicted branches since reset
// BEHAVIOUR
//  - E register fields: valid_e, pred_e, pc_e, target_e = PC_d+ImmExt_d (mod 2^DATA_WIDTH),
//    fallthru_e = PC_d+4 (mod 2^DATA_WIDTH). Both sums are computed in D and registered.
//  - Register priority each edge: rst > flush_e > self-flush > stall_e > load.
//    - rst: valid_e=0 and all fields 0; both counters 0.
//    - flush_e or self-flush: valid_e=0 (bubble), other fields don't-care.
//    - stall_e: all E fields hold.
//    - else: valid_e=Branch_d and other fields load from D.
//  - Self-flush: redirect_valid=1 loads a bubble on the next edge (D instr is wrong-path).
//  - Resolve (combinational from E regs and branch_cond_e):
//    - res = valid_e & !stall_e.
//    - mispredict_e = res & (branch_cond_e != pred_e).
//    - redirect_valid = flush_fd = mispredict_e.
//    - redirect_pc = branch_cond_e ? target_e : fallthru_e. Driven only when redirect_valid,
//      otherwise 0.
//  - Latency: branch in D at cycle N resolves in cycle N+1, or later if stalled. A redirect
//    is asserted for exactly one cycle per mispredicted branch. A stalled branch never
//    redirects while stalled.
//  - Counters, on res: branch_count+1; on mispredict_e: mispredict_count+1. Both saturate
//    at all-ones and never wrap. Each branch is counted exactly once.
//  - Reset values: redirect_valid=0, flush_fd=0, mispredict_e=0, redirect_pc=0, counters=0.
//  - Reset mid-operation: a pending E-stage branch is dropped with no redirect and no count.
//  - flush_e while a branch sits in E with stall_e=0: the branch still resolves this cycle.
//    The bubble loads on the edge.
//  - Non-branch instructions (Branch_d=0) never cause redirects, regardless of predict_taken_d.
// TESTING
//  1. PC_d=0x100, Imm=+0x20, pred=0, cond=1 -> next cycle redirect_valid=1, pc=0x120,
//     flush_fd=1 for one cycle; mispredict_count=1.
//  2. PC_d=0x200, Imm=-0x10, pred=1, cond=1 -> no redirect; branch_count=1, mispredict_count=0.
//  3. Mispredicted branch (pred=1, cond=0, PC=0x40) held by stall_e for 3 cycles -> no redirect
//     during stall; on release a single redirect with pc=0x44; counts +1 once.
//  4. Force both counters to 0xFFFFFFFF (CNT_WIDTH=32) and resolve a mispredict -> both stay
//     0xFFFFFFFF.
//  5. Mispredicted branch in E with rst=1 in the same cycle -> redirect_valid=0 after the edge;
//     counters 0; E empty.
//  6. Back-to-back mispredicts in D -> the first redirects; the second is squashed by
//     self-flush (no redirect, not counted).

Source files
------------

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage half of the static branch predictor. A decoded branch and its
// prediction are captured into the D->E register. In execute the prediction is
// compared against the real condition. On a mispredict, fetch is redirected to
// the correct path and the F/D stages are squashed for one cycle. Two
// saturating performance counters track resolved and mispredicted branches.
//
// Ports
//   clk               in   rising-edge clock for all state
//   rst               in   synchronous, active-high reset
//   stall_e           in   hold the E-stage register (hazard stall)
//   flush_e           in   load a bubble into the E-stage register
//   Branch_d          in   decode-stage instruction is a conditional branch
//   predict_taken_d   in   decode-stage prediction (1 = taken)
//   PC_d              in   PC of the decode-stage instruction
//   ImmExt_d          in   sign-extended branch offset
//   branch_cond_e     in   actual outcome of the E-stage branch (1 = taken)
//   redirect_valid    out  fetch must load redirect_pc this cycle
//   redirect_pc       out  corrected fetch address (0 when no redirect)
//   flush_fd          out  squash the F and D stage instructions
//   mispredict_e      out  E-stage branch resolved against its prediction
//   branch_count      out  resolved branches since reset (saturating)
//   mispredict_count  out  mispredicted branches since reset (saturating)
//
// Handshake: there is no valid/ready pair here. A branch in E is consumed in
// the first cycle it is valid with stall_e low; stall_e is the only
// backpressure and it simply freezes the E register.
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_e,
    input  logic                  flush_e,
    input  logic                  Branch_d,
    input  logic                  predict_taken_d,
    input  logic [DATA_WIDTH-1:0] PC_d,
    input  logic [DATA_WIDTH-1:0] ImmExt_d,
    input  logic                  branch_cond_e,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush_fd,
    output logic                  mispredict_e,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    // -------------------------------------------------------------------------
    // Decode stage: both candidate next-PCs are formed here so execute only
    // has to select between registered values.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] target_d;
    logic [DATA_WIDTH-1:0] fallthru_d;

    always_comb begin
        target_d   = PC_d + ImmExt_d;
        fallthru_d = PC_d + DATA_WIDTH'(4);
    end

    // -------------------------------------------------------------------------
    // D->E pipeline register
    // -------------------------------------------------------------------------
    logic                  valid_e;
    logic                  pred_e;
    logic [DATA_WIDTH-1:0] pc_e;
    logic [DATA_WIDTH-1:0] target_e;
    logic [DATA_WIDTH-1:0] fallthru_e;

    // A redirect means the instruction currently in D was fetched down the
    // wrong path, so the register must take a bubble instead of it. This
    // self-flush outranks stall_e, but a redirect can only happen with
    // stall_e low anyway.
    logic self_flush;

    always_comb begin
        self_flush = redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_e    <= 1'b0;
            pred_e     <= 1'b0;
            pc_e       <= '0;
            target_e   <= '0;
            fallthru_e <= '0;
        end else if (flush_e || self_flush) begin
            // Only valid matters for a bubble; the payload fields are left
            // as they are.
            valid_e <= 1'b0;
        end else if (!stall_e) begin
            valid_e    <= Branch_d;
            pred_e     <= predict_taken_d;
            pc_e       <= PC_d;
            target_e   <= target_d;
            fallthru_e <= fallthru_d;
        end
    end

    // -------------------------------------------------------------------------
    // Execute-stage resolution
    // -------------------------------------------------------------------------
    // A branch resolves in the first cycle it is valid and not stalled. Reset
    // also suppresses resolution, so a branch caught by reset is dropped
    // silently rather than redirecting fetch during the reset cycle.
    logic res;

    always_comb begin
        res            = valid_e && !stall_e && !rst;
        mispredict_e   = res && (branch_cond_e != pred_e);
        redirect_valid = mispredict_e;
        flush_fd       = mispredict_e;
        redirect_pc    = '0;
        if (mispredict_e) begin
            redirect_pc = branch_cond_e ? target_e : fallthru_e;
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters: saturate at all-ones and never wrap
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] branch_cnt_q;
    logic [CNT_WIDTH-1:0] mispredict_cnt_q;
    logic                 branch_cnt_full;
    logic                 mispredict_cnt_full;

    always_comb begin
        branch_cnt_full     = &branch_cnt_q;
        mispredict_cnt_full = &mispredict_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (res && !branch_cnt_full) begin
                branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
            end
            if (mispredict_e && !mispredict_cnt_full) begin
                mispredict_cnt_q <= mispredict_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        branch_count     = branch_cnt_q;
        mispredict_count = mispredict_cnt_q;
    end

    // pc_e is carried for debug visibility of the E-stage branch.
    logic [DATA_WIDTH-1:0] dbg_pc_e;

    always_comb begin
        dbg_pc_e = pc_e;
    end

    logic unused_dbg;

    always_comb begin
        unused_dbg = ^dbg_pc_e;
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit. Two instances share every input:
// the main one with 32-bit counters, and a narrow one with 3-bit counters so
// saturation can be reached quickly. A transaction-level model tracks the one
// branch that can sit in execute and derives expected outputs from the
// resolution rules; a scoreboard queue holds hand-computed redirect targets.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int DW      = 32;
    localparam int CW      = 32;
    localparam int CW_S    = 3;
    localparam longint SAT_S = 7;
    localparam longint SAT_M = 64'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          stall_e = 1'b0;
    logic          flush_e = 1'b0;
    logic          Branch_d = 1'b0;
    logic          predict_taken_d = 1'b0;
    logic [DW-1:0] PC_d = '0;
    logic [DW-1:0] ImmExt_d = '0;
    logic          branch_cond_e = 1'b0;

    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;
    logic          flush_fd;
    logic          mispredict_e;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    logic            s_redirect_valid;
    logic [DW-1:0]   s_redirect_pc;
    logic            s_flush_fd;
    logic            s_mispredict_e;
    logic [CW_S-1:0] s_branch_count;
    logic [CW_S-1:0] s_mispredict_count;

    branch_resolve_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_e          (stall_e),
        .flush_e          (flush_e),
        .Branch_d         (Branch_d),
        .predict_taken_d  (predict_taken_d),
        .PC_d             (PC_d),
        .ImmExt_d         (ImmExt_d),
        .branch_cond_e    (branch_cond_e),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush_fd         (flush_fd),
        .mispredict_e     (mispredict_e),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    branch_resolve_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW_S)) dut_small (
        .clk              (clk),
        .rst              (rst),
        .stall_e          (stall_e),
        .flush_e          (flush_e),
        .Branch_d         (Branch_d),
        .predict_taken_d  (predict_taken_d),
        .PC_d             (PC_d),
        .ImmExt_d         (ImmExt_d),
        .branch_cond_e    (branch_cond_e),
        .redirect_valid   (s_redirect_valid),
        .redirect_pc      (s_redirect_pc),
        .flush_fd         (s_flush_fd),
        .mispredict_e     (s_mispredict_e),
        .branch_count     (s_branch_count),
        .mispredict_count (s_mispredict_count)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    logic check_en = 1'b0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    // ---------------- behavioural model ----------------
    // The model holds the pending E-stage branch as a transaction (its PC,
    // offset and prediction) plus plain integer event counts.
    logic          m_valid = 1'b0;
    logic          m_pred = 1'b0;
    logic [DW-1:0] m_pc = '0;
    logic [DW-1:0] m_imm = '0;
    longint        m_bcnt = 0;
    longint        m_mcnt = 0;

    function automatic logic m_resolves();
        return m_valid && !stall_e && !rst;
    endfunction

    function automatic logic m_wrong();
        return m_resolves() && (branch_cond_e != m_pred);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_bcnt  <= 0;
            m_mcnt  <= 0;
        end else begin
            if (m_resolves()) m_bcnt <= m_bcnt + 1;
            if (m_wrong())    m_mcnt <= m_mcnt + 1;
            if (flush_e || m_wrong()) begin
                m_valid <= 1'b0;
            end else if (!stall_e) begin
                m_valid <= Branch_d;
                m_pred  <= predict_taken_d;
                m_pc    <= PC_d;
                m_imm   <= ImmExt_d;
            end
        end
    end

    // ---------------- compare process (opposite edge) ----------------
    always @(negedge clk) begin
        if (check_en) begin
            logic          e_mis;
            logic [DW-1:0] e_pc;
            e_mis = m_wrong();
            e_pc  = '0;
            if (e_mis) e_pc = branch_cond_e ? (m_pc + m_imm) : (m_pc + 32'd4);
            check("redirect_valid", 64'(redirect_valid), 64'(e_mis));
            check("flush_fd", 64'(flush_fd), 64'(e_mis));
            check("mispredict_e", 64'(mispredict_e), 64'(e_mis));
            check("redirect_pc", 64'(redirect_pc), 64'(e_pc));
            check("branch_count", 64'(branch_count), 64'(sat(m_bcnt, SAT_M)));
            check("mispredict_count", 64'(mispredict_count), 64'(sat(m_mcnt, SAT_M)));
            check("s_redirect_valid", 64'(s_redirect_valid), 64'(e_mis));
            check("s_branch_count", 64'(s_branch_count), 64'(sat(m_bcnt, SAT_S)));
            check("s_mispredict_count", 64'(s_mispredict_count), 64'(sat(m_mcnt, SAT_S)));
            // Scoreboard: every observed redirect must match the next
            // hand-computed target.
            if (redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_redirect", 64'(redirect_pc), 64'hDEAD_0000_0000);
                end else begin
                    check("sb_redirect_pc", 64'(redirect_pc), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic b, input logic p, input logic [DW-1:0] pc,
                        input logic [DW-1:0] imm, input logic cond,
                        input logic stl, input logic fl, input logic r);
        Branch_d        = b;
        predict_taken_d = p;
        PC_d            = pc;
        ImmExt_d        = imm;
        branch_cond_e   = cond;
        stall_e         = stl;
        flush_e         = fl;
        rst             = r;
        @(posedge clk);
        #1;
    endtask

    task automatic load_branch(input logic p, input logic [DW-1:0] pc, input logic [DW-1:0] imm);
        step(1'b1, p, pc, imm, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic cond);
        step(1'b0, 1'b0, '0, '0, cond, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_en = 1'b1;
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        check("rst_branch_count", 64'(branch_count), 64'd0);
        check("rst_mispredict_count", 64'(mispredict_count), 64'd0);

        // 1: not-taken prediction, branch taken -> redirect to 0x120
        load_branch(1'b0, 32'h100, 32'h20);
        exp_q.push_back(32'h120);
        resolve(1'b1);
        check("t1_mispredict_count", 64'(mispredict_count), 64'd1);
        resolve(1'b1);  // bubble follows: no second redirect

        // 5: mispredicted branch in E while reset is asserted -> dropped
        load_branch(1'b1, 32'h40, 32'h0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_branch_count", 64'(branch_count), 64'd0);
        check("t5_mispredict_count", 64'(mispredict_count), 64'd0);
        resolve(1'b0);  // E empty after reset

        // 2: taken prediction correct, negative offset
        load_branch(1'b1, 32'h200, 32'hFFFF_FFF0);
        resolve(1'b1);
        check("t2_branch_count", 64'(branch_count), 64'd1);
        check("t2_mispredict_count", 64'(mispredict_count), 64'd0);

        // 3: mispredict held by stall for 3 cycles, then one redirect to 0x44
        load_branch(1'b1, 32'h40, 32'h10);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h80, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("t3_count_during_stall", 64'(branch_count), 64'd1);
        exp_q.push_back(32'h44);
        step(1'b1, 1'b0, 32'h80, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_branch_count", 64'(branch_count), 64'd2);
        check("t3_mispredict_count", 64'(mispredict_count), 64'd1);
        resolve(1'b1);  // self-flushed D instr must not appear

        // flush_e with an unstalled branch in E: it still resolves
        load_branch(1'b1, 32'h600, 32'h100);
        step(1'b1, 1'b0, 32'h700, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0);
        resolve(1'b0);  // flushed 0x700 never reaches E
        check("flush_branch_count", 64'(branch_count), 64'd3);

        // flush_e together with stall: branch is never resolved or counted
        load_branch(1'b0, 32'h900, 32'h4);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        resolve(1'b1);
        check("stallflush_branch_count", 64'(branch_count), 64'd3);

        // Non-branch with a taken prediction never redirects
        step(1'b0, 1'b1, 32'h800, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        resolve(1'b0);

        // Address wrap: taken target and fall-through both wrap mod 2^32
        load_branch(1'b0, 32'hFFFF_FFF0, 32'h14);
        exp_q.push_back(32'h4);
        resolve(1'b1);
        load_branch(1'b1, 32'hFFFF_FFFC, 32'h40);
        exp_q.push_back(32'h0);
        resolve(1'b0);

        // 6: back-to-back mispredicts; the second is squashed
        load_branch(1'b0, 32'h300, 32'h8);
        exp_q.push_back(32'h308);
        step(1'b1, 1'b0, 32'h500, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        resolve(1'b1);
        check("t6_branch_count", 64'(branch_count), 64'd6);
        check("t6_mispredict_count", 64'(mispredict_count), 64'd4);

        // 4: saturation on the narrow instance (3-bit counters)
        for (int i = 0; i < 9; i++) begin
            load_branch(1'b0, 32'h1000 + 32'(i * 16), 32'h40);
            exp_q.push_back(32'h1040 + 32'(i * 16));
            resolve(1'b1);
        end
        check("t4_s_branch_sat", 64'(s_branch_count), 64'd7);
        check("t4_s_mispredict_sat", 64'(s_mispredict_count), 64'd7);
        check("t4_branch_count", 64'(branch_count), 64'd15);
        check("t4_mispredict_count", 64'(mispredict_count), 64'd13);

        resolve(1'b0);
        resolve(1'b0);
        check("sb_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
